// File: rtl/userType_pkg.sv
// Shared issue-path types and default sizing for the command issue FIFO.
// Contents: scheduler command encoding, packed issue-entry word,
// default depth and back-pressure margins.
package userType_pkg;

    // Scheduler command encoding carried in each issue entry.
    typedef enum logic [3:0] {
        CMD_NOP  = 4'h0,
        CMD_ACT  = 4'h1,
        CMD_RD   = 4'h2,
        CMD_WR   = 4'h3,
        CMD_PRE  = 4'h4,
        CMD_PREA = 4'h5,
        CMD_REF  = 4'h6,
        CMD_MRS  = 4'h7
    } sch_cmd_t;

    // One queued issue word: {command, row/col address, bank}.
    typedef struct packed {
        sch_cmd_t    command;
        logic [13:0] addr;
        logic [2:0]  bank;
    } issue_entry_t;

    localparam int unsigned ISU_ENTRY_W      = $bits(issue_entry_t);
    localparam int unsigned ISU_FIFO_DEPTH   = 32;
    localparam int unsigned ISU_FULL_MARGIN  = 4;
    localparam int unsigned ISU_VFULL_MARGIN = 8;

endpackage

// File: rtl/issue_fifo_param_if.sv
// Handshake/data bundle between the scheduler side and the issue FIFO.
// master: drives flush/wen/data_in/ren, observes queue state.
// slave : the FIFO itself.
interface issue_fifo_param_if
    import userType_pkg::*;
#(
    parameter int unsigned DATA_W = ISU_ENTRY_W,
    parameter int unsigned DEPTH  = ISU_FIFO_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              wen;
    logic [DATA_W-1:0] data_in;
    logic              ren;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_out_pre;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              virtual_full;
    logic              hard_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wen, data_in, ren,
        input  data_out, data_out_pre, count, empty, full,
               virtual_full, hard_full, overflow, underflow
    );

    modport slave (
        input  flush, wen, data_in, ren,
        output data_out, data_out_pre, count, empty, full,
               virtual_full, hard_full, overflow, underflow
    );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for the issue FIFO.
// Owns wrap-bit pointers, push/pop accept, occupancy, free-slot flags,
// flush/reset handling and (with ISSUE_FIFO_ERR_EN) sticky error flags.
// Ports: clk, rst_n (sync, active-low), flush, wen, ren in;
// wr_addr/rd_addr, push_c/pop_c (accept strobes), count, empty, full,
// virtual_full, hard_full, overflow, underflow out.
module fifo_ptr_ctrl
    import userType_pkg::*;
#(
    parameter int unsigned DEPTH        = ISU_FIFO_DEPTH,
    parameter int unsigned FULL_MARGIN  = ISU_FULL_MARGIN,
    parameter int unsigned VFULL_MARGIN = ISU_VFULL_MARGIN,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned PW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wen,
    input  logic          ren,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          push_c,
    output logic          pop_c,
    output logic [PW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          virtual_full,
    output logic          hard_full,
    output logic          overflow,
    output logic          underflow
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] free;

    // Occupancy from wrap-bit pointers; modulo subtraction handles wrap.
    assign count        = wr_ptr - rd_ptr;
    assign free         = PW'(DEPTH) - count;
    assign empty        = (count == '0);
    assign hard_full    = (count == PW'(DEPTH));
    assign full         = (free < PW'(FULL_MARGIN));
    assign virtual_full = (free < PW'(VFULL_MARGIN));

    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    // Accept decisions use pre-edge state, so a pop never frees room for a same-cycle push.
    assign push_c = rst_n & ~flush & wen & ~hard_full;
    assign pop_c  = rst_n & ~flush & ren & ~empty;

    // Pointer state; flush behaves like reset for the queue.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

`ifdef ISSUE_FIFO_ERR_EN
    // Sticky drop/ignore indicators, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && hard_full) overflow  <= 1'b1;
            if (ren && empty)     underflow <= 1'b1;
        end
    end

    // Flag each dropped push / ignored pop while simulating.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(wen && hard_full)) else $warning("issue_fifo: push dropped on hard_full");
            assert (!(ren && empty))     else $warning("issue_fifo: pop ignored on empty");
        end
    end
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: rtl/issue_fifo_param.sv
// Parametrised show-ahead command issue FIFO (scheduler -> DRAM issuer).
// Holds the entry memory, the show-ahead read mux and the registered
// "previously popped" word; pointer/flag logic lives in fifo_ptr_ctrl.
// Ports: clk, rst_n (sync, active-low), bus (issue_fifo_param_if.slave:
// flush, wen, data_in, ren in; data_out, data_out_pre, count, empty, full,
// virtual_full, hard_full, overflow, underflow out).
// Optional: define ISSUE_FIFO_ERR_EN for sticky overflow/underflow flags.
module issue_fifo_param
    import userType_pkg::*;
#(
    parameter int unsigned DATA_W       = ISU_ENTRY_W,
    parameter int unsigned DEPTH        = ISU_FIFO_DEPTH,
    parameter int unsigned FULL_MARGIN  = ISU_FULL_MARGIN,
    parameter int unsigned VFULL_MARGIN = ISU_VFULL_MARGIN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    issue_fifo_param_if.slave       bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic              push_c;
    logic              pop_c;
    logic [PW-1:0]     count;
    logic              empty;
    logic              full;
    logic              virtual_full;
    logic              hard_full;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] pre_q;

    fifo_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .FULL_MARGIN  (FULL_MARGIN),
        .VFULL_MARGIN (VFULL_MARGIN)
    ) u_ptr (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (bus.flush),
        .wen          (bus.wen),
        .ren          (bus.ren),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .push_c       (push_c),
        .pop_c        (pop_c),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .virtual_full (virtual_full),
        .hard_full    (hard_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Entry storage; intentionally not reset or cleared by flush.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_addr] <= bus.data_in;
    end

    // Show-ahead head word, forced to zero when nothing is queued.
    assign head = empty ? '0 : mem[rd_addr];

    // Last word consumed by an accepted pop.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            pre_q <= '0;
        end else if (pop_c) begin
            pre_q <= head;
        end
    end

    assign bus.data_out     = head;
    assign bus.data_out_pre = pre_q;
    assign bus.count        = count;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.virtual_full = virtual_full;
    assign bus.hard_full    = hard_full;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: doc/issue_fifo_param.md
# issue_fifo_param

Parametrised successor of the controller's command issue FIFO. It sits between the command scheduler and the DRAM command issuer and buffers issued {command, row/col address, bank} words in a show-ahead queue. Compared with the previous generation it adds:
- configurable width, depth and back-pressure margins
- all DEPTH entries usable
- an exact occupancy count
- a synchronous flush
- a registered "previously popped" word
- defined overflow and underflow behaviour

## Interface
Parameters:
- DATA_W, 21: entry width; packing {command, addr[13:0], bank[2:0]} per the shared issue-entry typedef.
- DEPTH, 32: number of entries; must be a power of two, ≥ 8.
- FULL_MARGIN, 4: `full` asserts when free slots < FULL_MARGIN.
- VFULL_MARGIN, 8: `virtual_full` asserts when free slots < VFULL_MARGIN; must be ≥ FULL_MARGIN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous queue clear.
- wen  in  1  push request.
- data_in  in  DATA_W  push data.
- ren  in  1  pop request.
- data_out  out  DATA_W  head entry (show-ahead).
- data_out_pre  out  DATA_W  entry removed by the most recent pop.
- count  out  $clog2(DEPTH)+1  occupancy.
- empty  out  1  count == 0.
- full  out  1  free < FULL_MARGIN.
- virtual_full  out  1  free < VFULL_MARGIN.
- hard_full  out  1  count == DEPTH.
- overflow  out  1  push dropped (see Configuration).
- underflow  out  1  pop on empty (see Configuration).

## Operation
- Pointers wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits; the MSB is a wrap bit.
  - count = wr_ptr − rd_ptr, modulo 2^(AW+1).
  - free = DEPTH − count.
- Push accepted = wen & ~hard_full.
  - An accepted push writes data_in to mem[wr_ptr[AW-1:0]] and increments wr_ptr.
  - `full` and `virtual_full` are advisory only; pushes are still accepted while they are high.
- Pop accepted = ren & ~empty.
  - An accepted pop increments rd_ptr and loads data_out_pre ← data_out.
- Simultaneous accepted push and pop: both pointers advance and count is unchanged.
  - On a full FIFO with wen & ren, the pop is accepted and the push is dropped, because hard_full is evaluated before the pop.
- Pop on empty: no state change; data_out_pre holds its value.
- Push on hard_full: data is discarded and pointers are unchanged.
- flush=1 (with rst_n=1): wr_ptr and rd_ptr are cleared to 0 and data_out_pre to 0.
  - flush has priority over wen and ren in the same cycle.
  - Memory contents are not cleared.
- data_out = mem[rd_ptr[AW-1:0]] when ~empty, else 0. It is combinational from the pointer and memory.
- Pointer wrap is natural modulo arithmetic; no special case at index DEPTH−1 → 0.
- Memory array is not reset.

## Timing
- Reset values: count=0, empty=1, full=0, virtual_full=0, hard_full=0, data_out=0, data_out_pre=0, overflow=0, underflow=0.
- Reset asserted mid-operation discards all queued entries in that same edge.
- Write latency: data pushed at edge N is visible on data_out after edge N when the queue was empty, i.e. 1 cycle.
- Flags and count are combinational from the pointers and are valid 1 cycle after the causing edge.
- There is no combinational path from wen/ren/data_in to any output.
- data_out_pre updates on the same edge as the pop that consumes the entry.

## Configuration
- ISSUE_FIFO_ERR_EN defined:
  - overflow is a sticky register, set on wen & hard_full.
  - underflow is a sticky register, set on ren & empty.
  - Both are cleared only by rst_n or flush.
  - A simulation-only assertion fires on each event.
- ISSUE_FIFO_ERR_EN undefined: overflow and underflow are tied to 0. Drop and ignore behaviour is unchanged.

## Structure
- userType_pkg carries:
  - sch_cmd_t
  - the packed issue-entry struct {sch_cmd_t command; logic[13:0] addr; logic[2:0] bank}
  - default constants ISU_FIFO_DEPTH=32, ISU_FULL_MARGIN=4, ISU_VFULL_MARGIN=8
- One sub-module, fifo_ptr_ctrl, contains:
  - the pointers
  - accept logic
  - count, free and all flags
  - the flush and reset handling
- The top level holds the memory array, the read mux and the data_out_pre register.

## Test plan
- Reset, then idle → count=0, empty=1, all other flags 0, data_out=0.
- Push 0x00001…0x00020 (32 words), then pop 32 → FIFO order preserved; the count and flags below hold on the push/pop edges stated:
  - after 25 pushes: virtual_full=1
  - after 29 pushes: full=1
  - after 32 pushes: hard_full=1
  - each pop: data_out_pre equals the word just popped
- At count=32: wen with data 0x1ABCD → word dropped, count stays 32, overflow=1 (ERR_EN).
  - Next, wen & ren together → pop accepted, push dropped, count=31.
- At count=5: wen & ren for 40 cycles, which wraps the pointers → count stays 5, FIFO order is preserved across the index 31→0 boundary.
- ren on empty → count=0, data_out_pre unchanged, underflow=1 (ERR_EN) or 0 (no macro).
- At count=10: flush together with wen → count=0, empty=1, sticky flags cleared.
  - Next push of 0x0F0F0: data_out=0x0F0F0 one cycle later.
